// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants, FSM state type and counter helpers for branch_resolve_ctrl
// and its branch history table (enabled with BRANCH_BHT_EN).
package branch_resolve_ctrl_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

  localparam logic [1:0] BHT_CTR_RESET = 2'b01;

  function automatic logic br_funct3_legal(input logic [2:0] funct3);
    logic legal;
    case (funct3)
      BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Illegal encodings resolve as not-taken so the mispredict check still works.
  function automatic logic br_taken(input logic [2:0] funct3,
                                    input logic       eq,
                                    input logic       lt);
    logic taken;
    case (funct3)
      BR_BEQ:           taken = eq;
      BR_BNE:           taken = ~eq;
      BR_BLT, BR_BLTU:  taken = lt;
      BR_BGE, BR_BGEU:  taken = ~lt;
      default:          taken = 1'b0;
    endcase
    return taken;
  endfunction

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr,
                                            input logic       taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end else begin
      nxt = (ctr == 2'b00) ? ctr : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_bht.sv
// branch_bht: table of 2-bit saturating counters with a combinational fetch
// read port and a single resolve-time update port.
module branch_bht
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [IDX_W-1:0] fetch_idx,
  output logic             fetch_pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] table_r [ENTRIES];

  // Counter table: reset to weakly not-taken, one saturating update per cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i] <= BHT_CTR_RESET;
      end
    end else if (upd_valid) begin
      table_r[upd_idx] <= ctr_update(table_r[upd_idx], upd_taken);
    end
  end

  // Reads the registered array, so a same-cycle write to this index is not yet visible.
  assign fetch_pred_taken = table_r[fetch_idx][1];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution: taken decode, mispredict redirect, timed IF/ID flush and
// mispredict counter. Define BRANCH_BHT_EN to build the dynamic predictor table.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int BHT_ENTRIES  = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        br_valid,
  input  logic [2:0]  br_funct3,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  input  logic        br_pred,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        BrUn,
  input  logic [31:0] fetch_pc,
  output logic        fetch_pred_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        illegal_br,
  output logic [15:0] mispredict_cnt
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  br_state_e   state_r, state_nxt_s;
  logic        redirect_valid_r, redirect_valid_nxt_s;
  logic [31:0] redirect_pc_r, redirect_pc_nxt_s;
  logic        flush_r, flush_nxt_s;
  logic [2:0]  flush_cnt_r, flush_cnt_nxt_s;
  logic        illegal_r, illegal_nxt_s;
  logic [15:0] mispredict_cnt_r, mispredict_cnt_nxt_s;

  logic        legal_s;
  logic        taken_s;
  logic        accept_s;
  logic        mispredict_s;
  logic        fetch_pc_unused_s;

  assign BrUn         = br_funct3[1];
  assign legal_s      = br_funct3_legal(br_funct3);
  assign taken_s      = br_taken(br_funct3, BrEq, BrLT);
  assign accept_s     = br_valid && (state_r == IDLE);
  assign mispredict_s = accept_s && (taken_s != br_pred);

  // Next-state and next-output logic for the IDLE/FLUSH controller.
  always_comb begin
    state_nxt_s          = state_r;
    redirect_valid_nxt_s = 1'b0;
    redirect_pc_nxt_s    = redirect_pc_r;
    flush_nxt_s          = flush_r;
    flush_cnt_nxt_s      = flush_cnt_r;
    illegal_nxt_s        = 1'b0;
    mispredict_cnt_nxt_s = mispredict_cnt_r;
    case (state_r)
      IDLE: begin
        flush_nxt_s   = 1'b0;
        illegal_nxt_s = accept_s && !legal_s;
        if (mispredict_s) begin
          state_nxt_s          = FLUSH;
          redirect_valid_nxt_s = 1'b1;
          redirect_pc_nxt_s    = taken_s ? br_target : (br_pc + 32'd4);
          flush_nxt_s          = 1'b1;
          flush_cnt_nxt_s      = FLUSH_LAST;
          if (mispredict_cnt_r != 16'hFFFF) begin
            mispredict_cnt_nxt_s = mispredict_cnt_r + 16'd1;
          end else begin
            mispredict_cnt_nxt_s = mispredict_cnt_r;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == 3'd0) begin
          state_nxt_s = IDLE;
          flush_nxt_s = 1'b0;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r - 3'd1;
          flush_nxt_s     = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        flush_nxt_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update; Reset also aborts an active flush.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r          <= IDLE;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
      flush_r          <= 1'b0;
      flush_cnt_r      <= 3'd0;
      illegal_r        <= 1'b0;
      mispredict_cnt_r <= 16'd0;
    end else begin
      state_r          <= state_nxt_s;
      redirect_valid_r <= redirect_valid_nxt_s;
      redirect_pc_r    <= redirect_pc_nxt_s;
      flush_r          <= flush_nxt_s;
      flush_cnt_r      <= flush_cnt_nxt_s;
      illegal_r        <= illegal_nxt_s;
      mispredict_cnt_r <= mispredict_cnt_nxt_s;
    end
  end

  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign flush          = flush_r;
  assign illegal_br     = illegal_r;
  assign mispredict_cnt = mispredict_cnt_r;

  // Only the index bits of fetch_pc feed the table; the rest are intentionally dropped.
  assign fetch_pc_unused_s = ^fetch_pc;

`ifdef BRANCH_BHT_EN
  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

  logic bht_upd_s;
  assign bht_upd_s = accept_s && legal_s;

  branch_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (BHT_IDX_W)
  ) u_bht (
    .Clock            (Clock),
    .Reset            (Reset),
    .fetch_idx        (fetch_pc[BHT_IDX_W+1:2]),
    .fetch_pred_taken (fetch_pred_taken),
    .upd_valid        (bht_upd_s),
    .upd_idx          (br_pc[BHT_IDX_W+1:2]),
    .upd_taken        (taken_s)
  );
`else
  assign fetch_pred_taken = 1'b0;
`endif

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush is held after a mispredict (legal range 1..7).
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, meaning the predictor table depth (power of 2).
REQ-003 SHALL have the following ports, one per line:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- br_valid  in  1  a branch instruction is in EX this cycle.
- br_funct3  in  3  branch funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
- br_pc  in  32  PC of the EX branch.
- br_target  in  32  computed branch target.
- br_pred  in  1  prediction made at fetch, carried down the pipeline.
- BrEq  in  1  comparator equal result.
- BrLT  in  1  comparator less-than result.
- BrUn  out  1  comparator unsigned select.
- fetch_pc  in  32  PC being fetched.
- fetch_pred_taken  out  1  prediction for fetch_pc.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  32  corrected PC.
- flush  out  1  kill the IF/ID instructions.
- illegal_br  out  1  one-cycle pulse on an illegal funct3.
- mispredict_cnt  out  16  count of mispredicts.

Function
REQ-004 SHALL drive BrUn = br_funct3[1] combinationally.
REQ-005 SHALL decode taken as follows:
- BEQ = BrEq; BNE = !BrEq.
- BLT/BLTU = BrLT; BGE/BGEU = !BrLT.
- funct3 010/011 = not taken.
REQ-006 SHALL have states IDLE and FLUSH.
REQ-007 IDLE SHALL, on br_valid with taken != br_pred:
- register redirect_valid=1 for exactly the next cycle;
- set redirect_pc = taken ? br_target : br_pc+4, with the +4 wrapping modulo 2^32;
- enter FLUSH.
REQ-008 IDLE SHALL, on br_valid with taken == br_pred, produce no redirect or flush and stay in IDLE.
REQ-009 flush SHALL be high for exactly FLUSH_CYCLES consecutive cycles, starting the same cycle redirect_valid is high.
REQ-010 On FLUSH_CYCLES expiry the block SHALL return to IDLE.
REQ-011 In FLUSH, br_valid SHALL be ignored: no redirect, no BHT update, no count.
REQ-012 br_valid arriving on the first IDLE cycle after FLUSH SHALL be processed normally.
REQ-013 redirect_pc SHALL hold its last value when redirect_valid is low.
REQ-014 On illegal funct3 with br_valid in IDLE:
- illegal_br SHALL pulse the next cycle;
- the branch SHALL be treated as not-taken for the mispredict check;
- no BHT update SHALL occur.
REQ-015 mispredict_cnt SHALL increment once per redirect and saturate at 16'hFFFF.

Reset
REQ-016 While Reset is high, the following SHALL apply on the next rising edge:
- state=IDLE;
- redirect_valid=0, flush=0, illegal_br=0;
- redirect_pc=0, mispredict_cnt=0;
- all BHT entries=2'b01.
REQ-017 Reset asserted mid-FLUSH SHALL abort the flush; flush is low the cycle after Reset is sampled.
REQ-018 br_valid SHALL be ignored while Reset is high.

Configuration
REQ-019 Macro BRANCH_BHT_EN defined SHALL instantiate a BHT_ENTRIES x 2-bit saturating-counter table, behaving as follows:
- fetch index = fetch_pc[log2(BHT_ENTRIES)+1:2];
- fetch_pred_taken = entry[1], read combinationally;
- update index = br_pc bits, same slice;
- update +1 on taken, -1 on not-taken, saturating at 0 and 3;
- update only for legal branches in IDLE;
- same-index read and write in one cycle returns the pre-update value.
REQ-020 With BRANCH_BHT_EN undefined, the following SHALL apply:
- no table is built;
- fetch_pred_taken = 0 (static not-taken);
- all other behaviour is unchanged.

Structure
REQ-021 The shared package SHALL hold:
- funct3 constants BR_BEQ..BR_BGEU;
- the state enum {IDLE, FLUSH};
- the 2-bit counter reset value 2'b01.
REQ-022 The BHT SHALL be one sub-module, branch_bht, containing the table, read port and update logic; branch_resolve_ctrl holds the FSM, flush counter and mispredict counter.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- BEQ, BrEq=1, br_pred=0, br_target=32'h100 -> next cycle redirect_valid=1, redirect_pc=32'h100; flush high 2 cycles; mispredict_cnt=1.
- BLTU, BrLT=0, br_pred=0 -> BrUn=1; no redirect; flush stays 0.
- BGE, BrLT=0, br_pred=1 -> no redirect. Same BGE with BrLT=1 -> redirect_pc = br_pc+4; br_pc=32'hFFFFFFFC gives 32'h0.
- Mispredict followed by br_valid mispredicts in both FLUSH cycles -> only one redirect; mispredict_cnt +1 total.
- BRANCH_BHT_EN, br_pc=32'h40, three taken BEQs -> entry 01->10->11->11; fetch_pc=32'h40 gives fetch_pred_taken=1; fetch_pc=32'h44 gives 0.
- funct3=3'b010, br_pred=1 -> illegal_br pulse and redirect to br_pc+4. Separately, Reset in FLUSH cycle 1 -> flush=0 next cycle and mispredict_cnt=0.
